// File: rtl/digitube_scan_ctrl.sv
// Self-scanning multi-digit 7-segment driver: shadow-latches a packed hex value and time-multiplexes the digits.
// Optional leading-zero blanking is compiled in with the DIGITUBE_LZB_EN macro.
module digitube_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    scan_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0]  DIV_LAST = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [DIV_WIDTH-1:0]    div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              nib;
  logic [6:0]              seg_next;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

`ifdef DIGITUBE_LZB_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  all_zero;

  // Digit i>0 blanks when it and every more-significant nibble are zero.
  always_comb begin
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero & (shadow_val[4*i +: 4] == 4'h0);
      lz_blank[i] = all_zero;
    end
  end
`endif

  always_comb begin
    nib      = shadow_val[{idx, 2'b00} +: 4];
    seg_next = decode(nib);
`ifdef DIGITUBE_LZB_EN
    if (lz_blank[idx]) seg_next = 7'h7F;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_mask;
    end
  end

  // Pins are registered from the current idx/shadow so an, seg and dp always switch together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      idx       <= '0;
      scan_tick <= 1'b0;
      an        <= '0;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else if (!enable) begin
      div_cnt   <= '0;
      idx       <= '0;
      scan_tick <= 1'b0;
      an        <= '0;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      an  <= AN_ONE << idx;
      seg <= seg_next;
      dp  <= ~shadow_dp[idx];
      if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        scan_tick <= 1'b1;
      end else begin
        div_cnt   <= div_cnt + 1'b1;
        scan_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digitube_scan_ctrl.sv
// Directed bench for digitube_scan_ctrl (4 digits, 4-cycle dwell); expectations are hand-derived tables.
module tb_digitube_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  int vectors = 0;
  int miscompares = 0;

  digitube_scan_ctrl #(
    .NUM_DIGITS(4),
    .DIV_WIDTH (16),
    .SCAN_DIV  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .value    (value),
    .dp_mask  (dp_mask),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp);
    chk({tag, "_an"}, 32'(an), 32'(e_an));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    chk({tag, "_dp"}, 32'(dp), 32'(e_dp));
  endtask

  logic [6:0] dec_tab [4];
  logic [6:0] lz_tab  [4];
  logic [3:0] e_an;
  int         d;

  initial begin
    dec_tab = '{7'h0E, 7'h08, 7'h24, 7'h79};
`ifdef DIGITUBE_LZB_EN
    lz_tab  = '{7'h40, 7'h30, 7'h7F, 7'h7F};
`else
    lz_tab  = '{7'h40, 7'h30, 7'h40, 7'h40};
`endif
    reset   = 1'b0;
    enable  = 1'b0;
    load    = 1'b0;
    value   = 16'h0000;
    dp_mask = 4'b0000;

    // Reset held: pins blank.
    tick(); tick();
    chk_pins("reset", 4'b0000, 7'h7F, 1'b1);
    chk("reset_tick", 32'(scan_tick), 32'd0);

    // Scan order: 4 cycles per digit, tick on every 4th cycle.
    enable = 1'b1;
    tick();
    chk_pins("reset_en", 4'b0000, 7'h7F, 1'b1);
    reset = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      e_an = 4'b0001 << (((c - 1) / 4) % 4);
      chk($sformatf("scan_an_%0d", c), 32'(an), 32'(e_an));
      chk($sformatf("scan_tick_%0d", c), 32'(scan_tick), 32'((c % 4) == 0));
    end
    chk_pins("scan_zero", 4'b0001, 7'h40, 1'b1);

    // Resync with one disabled cycle, then decode 12AF with dp on digit 2.
    enable = 1'b0;
    tick();
    chk_pins("resync", 4'b0000, 7'h7F, 1'b1);
    enable  = 1'b1;
    load    = 1'b1;
    value   = 16'h12AF;
    dp_mask = 4'b0100;
    tick();
    chk_pins("dec_stale", 4'b0001, 7'h40, 1'b1);
    load = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      d = ((c - 1) / 4) % 4;
      chk_pins($sformatf("dec_%0d", c), 4'b0001 << d, dec_tab[d], (d == 2) ? 1'b0 : 1'b1);
    end

    // Disable mid digit 2, then re-enable: full dwell on digit 0.
    enable = 1'b0;
    tick();
    chk_pins("dis", 4'b0000, 7'h7F, 1'b1);
    chk("dis_tick", 32'(scan_tick), 32'd0);
    tick();
    chk_pins("dis_hold", 4'b0000, 7'h7F, 1'b1);
    enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk_pins($sformatf("reen_%0d", c), 4'b0001, 7'h0E, 1'b1);
      chk($sformatf("reen_tick_%0d", c), 32'(scan_tick), 32'(c == 4));
    end
    tick();
    chk_pins("reen_5", 4'b0010, 7'h08, 1'b1);

    // Load 0000, then FFFF on the wrap edge: next digit is 0E from its first cycle.
    load    = 1'b1;
    value   = 16'h0000;
    dp_mask = 4'b0000;
    tick();
    chk_pins("wrap_stale", 4'b0010, 7'h08, 1'b1);
    tick();
    chk_pins("wrap_zero", 4'b0010, 7'h40, 1'b1);
    value = 16'hFFFF;
    tick();
    chk_pins("wrap_edge", 4'b0010, 7'h40, 1'b1);
    chk("wrap_edge_tick", 32'(scan_tick), 32'd1);
    load = 1'b0;
    for (int c = 9; c <= 13; c++) begin
      tick();
      chk_pins($sformatf("wrap_%0d", c), (c <= 12) ? 4'b0100 : 4'b1000, 7'h0E, 1'b1);
    end

    // Leading-zero pattern 0030.
    enable = 1'b0;
    load   = 1'b1;
    value  = 16'h0030;
    tick();
    enable = 1'b1;
    load   = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      d = (c - 1) / 4;
      chk_pins($sformatf("lz_%0d", c), 4'b0001 << d, lz_tab[d], 1'b1);
    end

    // Asynchronous reset mid-scan, then restart at digit 0 with cleared shadow.
    #2 reset = 1'b0;
    #1;
    chk_pins("areset", 4'b0000, 7'h7F, 1'b1);
    chk("areset_tick", 32'(scan_tick), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_pins("restart", 4'b0001, 7'h40, 1'b1);
    chk("restart_tick", 32'(scan_tick), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
